// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_DEF = 4;

endpackage

// File: rtl/serial_sub_fs.sv
// One-bit full subtractor: d = a - b - bi, with borrow-out bo.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: {Bo,D} = A - B - Bi, LSB first, one bit per clock.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bi,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         Bo
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, d_q, d_d;
  logic           br_q, br_d, bo_q, bo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bit_d, bit_bo;

  fs_cell u_fs_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = A;
          b_d     = B;
          br_d    = Bi;
          cnt_d   = '0;
          d_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Difference bits enter at the MSB so bit 0 lands in D[0] after N shifts.
        a_d   = {1'b0, a_q[N-1:1]};
        b_d   = {1'b0, b_q[N-1:1]};
        d_d   = {bit_d, d_q[N-1:1]};
        br_d  = bit_bo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bo_d    = bit_bo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bo   = bo_q;

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter N, default 4, operand width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE or DONE.
REQ-005 A  input  N  minuend; sampled on the accepted start cycle.
REQ-006 B  input  N  subtrahend; sampled on the accepted start cycle.
REQ-007 Bi  input  1  borrow-in; sampled on the accepted start cycle.
REQ-008 busy  output  1  high while the operation is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse when D and Bo become valid.
REQ-010 D  output  N  difference.
REQ-011 Bo  output  1  borrow-out.

Function
REQ-012 Result SHALL be {Bo,D} = A - B - Bi modulo 2^(N+1), so Bo=1 iff A < B+Bi.
REQ-013 Computation SHALL be bit-serial, LSB first, one bit per clock, using a single borrow flip-flop.
REQ-014 Per-bit rule: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
- IDLE -> SHIFT on start.
- SHIFT -> DONE after exactly N bit cycles.
- DONE -> SHIFT on start, otherwise DONE -> IDLE.
REQ-016 On accepted start the block SHALL latch A, B into shift registers, load br<=Bi, clear the bit counter, and clear D.
REQ-017 Each SHIFT cycle SHALL shift the computed bit d into D from the MSB side, so that after N cycles D[0] holds bit 0.
REQ-018 Latency: start sampled high at edge k SHALL give done=1 during the cycle after edge k+N, with D and Bo valid in that cycle.
REQ-019 Bo SHALL take the final br value on the same edge that enters DONE.
REQ-020 D and Bo SHALL hold their values after DONE until the next accepted start.
REQ-021 start while busy=1 SHALL be ignored, with no effect on operands, counter or result.
REQ-022 Changes on A, B or Bi after the start cycle SHALL NOT affect the result.
REQ-023 start asserted continuously SHALL produce back-to-back operations, one every N+1 cycles.
REQ-024 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from inputs.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, D 0, Bo 0, br 0, counter 0, shift registers 0.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first accepted start SHALL behave exactly as a start after power-up.

Structure
REQ-028 A shared package serial_sub_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and the default width constant N_DEF=4.
REQ-029 The per-bit borrow logic SHALL be one combinational sub-module fs_cell (ports a, b, bi -> d, bo), instantiated once.
REQ-030 The counter SHALL be $clog2(N)+1 bits wide; no other arithmetic operators are used on the datapath.

Verification (N=4)
REQ-031 A=5, B=3, Bi=0, start pulse -> done 5 cycles later; D=2, Bo=0.
REQ-032 A=3, B=5, Bi=0 -> D=14, Bo=1; A=0, B=0, Bi=1 -> D=15, Bo=1.
REQ-033 A=15, B=15, Bi=1 -> D=15, Bo=1; A=9, B=4, Bi=1 -> D=4, Bo=0.
REQ-034 start re-pulsed with A=1, B=1 during SHIFT of 5-3 -> ignored; result D=2, Bo=0.
REQ-035 rst_n pulsed low two cycles into SHIFT -> all outputs 0 immediately; no done pulse; a following 7-2 gives D=5, Bo=0.
REQ-036 Exhaustive sweep of all A, B, Bi combinations against the reference model A-B-Bi, including back-to-back starts -> zero mismatches; done spacing of 5 cycles.
